if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Parametrised instruction-fetch front end for the rv32i pipeline. It issues in-order instruction reads to the IMEM master interface, with up to MAX_OUTSTANDING reads in flight. Returned words are buffered with their PC in a DEPTH-entry FIFO. The FIFO drives the IF-ID buffer through a valid/ready handshake. On a jump or branch redirect it flushes the FIFO and silently discards stale responses, replacing the single-PC latch and fixed jump-penalty flush.

Parameters:
XLEN, 32, data/address width
DEPTH, 4, FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max accepted-but-unreturned IMEM reads (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
redirect_en  in  1  taken jump/branch from EX
redirect_pc  in  XLEN  redirect target (word aligned)
imem_addr  out  XLEN  fetch address
imem_ren  out  1  read request
imem_raddr_handshake  in  1  address accepted this cycle
imem_rdata_handshake  in  1  read data valid this cycle
imem_rdata  in  XLEN  returned instruction
inst_valid_o  out  1  FIFO head valid
inst_ready_i  in  1  IF-ID accepts head (deassert for stall)
inst_o  out  XLEN  head instruction
pc_o  out  XLEN  head PC
pc_next_o  out  XLEN  head PC + 4

Behaviour:
- Reset (async): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=RUN. Outputs: imem_ren=0, imem_addr=RESET_PC, inst_valid_o=0, inst_o/pc_o=0, pc_next_o=4.
- Issue: imem_ren = !redirect_en && outstanding<MAX_OUTSTANDING && (count+outstanding-drop_cnt)<DEPTH. Credit reservation guarantees FIFO never overflows.
- imem_addr = fetch_pc. On imem_raddr_handshake: fetch_pc += 4, and the address fetch_pc is pushed into an internal in-order PC tag queue (depth MAX_OUTSTANDING).
- outstanding counts accepted requests minus rdata handshakes. A simultaneous accept and return leaves it unchanged.
- Response in RUN: {imem_rdata, tag-queue head} is pushed to the FIFO and the tag is popped. It is visible at inst_valid_o the next cycle (latency 1 from rdata handshake).
- Pop: inst_valid_o && inst_ready_i. Simultaneous push and pop are allowed at any count, including full.
- FSM:
  - RUN -> DRAIN on redirect_en when outstanding_next>0, where outstanding_next excludes a response returning in the same cycle.
  - RUN -> RUN on redirect_en when outstanding_next==0.
  - DRAIN: each rdata handshake decrements drop_cnt and pops a tag. Nothing is enqueued.
  - DRAIN -> RUN when drop_cnt==1 and rdata handshake.
  - Redirect while in DRAIN: drop_cnt reloaded to outstanding_next, stay in DRAIN.
  - New requests may issue in DRAIN. Responses are strictly in order, so the first drop_cnt responses are stale.
- Any redirect: FIFO cleared, tag queue keeps only the entries still to be dropped, fetch_pc=redirect_pc. inst_valid_o=0 the next cycle. A response arriving in the redirect cycle is discarded.
- Redirect has priority over push and pop in the same cycle.
- Rdata handshake with outstanding==0 is a protocol error and is ignored (assertion in sim).
- pc arithmetic wraps modulo 2^XLEN.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_dropped_o[31:0] (stale responses discarded) and perf_empty_o[31:0] (cycles with inst_valid_o=0 and inst_ready_i=1). Both are saturating, reset to 0, and hold at 32'hFFFF_FFFF. When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, raddr/rdata handshakes every cycle, ready=1 -> addresses 0x0,0x4,0x8,...; pc_o follows the same sequence one cycle after each rdata; pc_next_o=pc_o+4.
- ready=0 for 10 cycles, DEPTH=4, MAX_OUTSTANDING=2 -> at most 4 entries buffered; imem_ren drops to 0 once count+outstanding=4; no entry lost or duplicated after ready=1.
- Two requests outstanding (0x10,0x14), redirect_pc=0x100 -> both responses discarded; first delivered pc_o=0x100; FETCH_PERF_CNT_EN: perf_dropped_o=2.
- Redirect in the same cycle as a response and a pop -> FIFO empty next cycle; response not enqueued; drop_cnt=remaining outstanding.
- Back-to-back redirects to 0x200 then 0x300 while in DRAIN -> only 0x300 stream delivered; no 0x200 instruction appears.
- ARESETn asserted mid-DRAIN with full FIFO -> all state cleared immediately; fetch resumes at RESET_PC after release.

Source files
------------

// File: rtl/if_fetch_queue.sv
// In-order IMEM fetch front end: PC-tagged instruction FIFO with credit-based issue and a
// redirect flush that silently drops stale responses. Define FETCH_PERF_CNT_EN for perf counters.
module if_fetch_queue #(
   parameter int unsigned XLEN            = 32,
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic            ACLK,
   input  logic            ARESETn,
   input  logic            redirect_en,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] imem_addr,
   output logic            imem_ren,
   input  logic            imem_raddr_handshake,
   input  logic            imem_rdata_handshake,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_o,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]     perf_dropped_o,
   output logic [31:0]     perf_empty_o,
`endif
   output logic [XLEN-1:0] pc_next_o
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic {StRun, StDrain} state_e;

   state_e          r_state, w_state_d;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_fifo_inst [DEPTH];
   logic [XLEN-1:0] r_fifo_pc   [DEPTH];
   logic [PW-1:0]   r_wptr, r_rptr;
   logic [CW-1:0]   r_count, r_out_cnt, r_drop_cnt;
   logic [XLEN-1:0] r_tag [MAX_OUTSTANDING];
   logic [TW-1:0]   r_tag_wptr, r_tag_rptr;

   logic            w_accept, w_ret, w_push, w_pop, w_drop;
   logic [CW-1:0]   w_out_d, w_drop_d;
   logic [CW:0]     w_used;
   logic [TW-1:0]   w_tag_wptr_nxt, w_tag_rptr_nxt;

   // Live credits: buffered entries plus in-flight reads that will not be dropped.
   assign w_used   = {1'b0, r_count} + {1'b0, r_out_cnt} - {1'b0, r_drop_cnt};
   assign imem_ren = ARESETn && !redirect_en && (r_out_cnt < CW'(MAX_OUTSTANDING))
                     && (w_used < (CW+1)'(DEPTH));
   assign imem_addr = r_fetch_pc;

   assign w_accept = imem_ren && imem_raddr_handshake;
   assign w_ret    = imem_rdata_handshake && (r_out_cnt != '0);
   assign w_push   = w_ret && (r_state == StRun) && !redirect_en;
   assign w_pop    = inst_valid_o && inst_ready_i && !redirect_en;
   assign w_drop   = w_ret && (redirect_en || (r_state == StDrain));
   assign w_out_d  = r_out_cnt + CW'(w_accept) - CW'(w_ret);

   assign w_tag_wptr_nxt = (r_tag_wptr == TW'(MAX_OUTSTANDING - 1)) ? '0 : r_tag_wptr + TW'(1);
   assign w_tag_rptr_nxt = (r_tag_rptr == TW'(MAX_OUTSTANDING - 1)) ? '0 : r_tag_rptr + TW'(1);

   assign inst_valid_o = (r_count != '0);
   assign inst_o       = r_fifo_inst[r_rptr];
   assign pc_o         = r_fifo_pc[r_rptr];
   assign pc_next_o    = pc_o + XLEN'(4);

   always_comb begin
      w_state_d = r_state;
      w_drop_d  = r_drop_cnt;
      if (redirect_en) begin
         // Everything still in flight after this cycle belongs to the old stream.
         w_drop_d  = w_out_d;
         w_state_d = (w_out_d != '0) ? StDrain : StRun;
      end else if ((r_state == StDrain) && w_ret) begin
         w_drop_d = r_drop_cnt - CW'(1);
         if (r_drop_cnt == CW'(1)) w_state_d = StRun;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state    <= StRun;
         r_fetch_pc <= RESET_PC;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_out_cnt  <= '0;
         r_drop_cnt <= '0;
         r_tag_wptr <= '0;
         r_tag_rptr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_fifo_inst[i] <= '0;
            r_fifo_pc[i]   <= '0;
         end
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) r_tag[i] <= '0;
      end else begin
         r_state    <= w_state_d;
         r_drop_cnt <= w_drop_d;
         r_out_cnt  <= w_out_d;
         if (w_accept) begin
            r_tag[r_tag_wptr] <= r_fetch_pc;
            r_tag_wptr        <= w_tag_wptr_nxt;
         end
         if (w_ret) r_tag_rptr <= w_tag_rptr_nxt;
         if (redirect_en) begin
            r_fetch_pc <= redirect_pc;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
         end else begin
            if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(4);
            if (w_push) begin
               r_fifo_inst[r_wptr] <= imem_rdata;
               r_fifo_pc[r_wptr]   <= r_tag[r_tag_rptr];
               r_wptr              <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_dropped, r_perf_empty;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_perf_dropped <= '0;
         r_perf_empty   <= '0;
      end else begin
         if (w_drop && (r_perf_dropped != '1)) r_perf_dropped <= r_perf_dropped + 32'd1;
         if (!inst_valid_o && inst_ready_i && (r_perf_empty != '1)) begin
            r_perf_empty <= r_perf_empty + 32'd1;
         end
      end
   end

   assign perf_dropped_o = r_perf_dropped;
   assign perf_empty_o   = r_perf_empty;
`endif

`ifndef SYNTHESIS
   a_rdata_without_read: assert property (@(posedge ACLK) disable iff (!ARESETn)
      !(imem_rdata_handshake && (r_out_cnt == '0)))
      else $error("imem rdata handshake with no outstanding read");
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: reset/table vectors, directed redirect corners, then random traffic
// checked against a queue-based reference model. Honours FETCH_PERF_CNT_EN.
module tb_if_fetch_queue;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXO  = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic        redirect_en = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr;
   logic        imem_ren;
   logic        imem_raddr_handshake = 1'b0;
   logic        imem_rdata_handshake = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        inst_valid_o;
   logic        inst_ready_i = 1'b0;
   logic [31:0] inst_o, pc_o, pc_next_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_dropped_o, perf_empty_o;
`endif

   if_fetch_queue #(
      .XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
   ) dut (
      .ACLK                 (ACLK),
      .ARESETn              (ARESETn),
      .redirect_en          (redirect_en),
      .redirect_pc          (redirect_pc),
      .imem_addr            (imem_addr),
      .imem_ren             (imem_ren),
      .imem_raddr_handshake (imem_raddr_handshake),
      .imem_rdata_handshake (imem_rdata_handshake),
      .imem_rdata           (imem_rdata),
      .inst_valid_o         (inst_valid_o),
      .inst_ready_i         (inst_ready_i),
      .inst_o               (inst_o),
      .pc_o                 (pc_o),
`ifdef FETCH_PERF_CNT_EN
      .perf_dropped_o       (perf_dropped_o),
      .perf_empty_o         (perf_empty_o),
`endif
      .pc_next_o            (pc_next_o)
   );

   always #5 ACLK = ~ACLK;

   typedef struct { logic [31:0] pc; bit stale; } tag_t;
   typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
   typedef struct {
      bit raddr; bit rdata; bit ready;
      bit exp_ren; logic [31:0] exp_addr; bit exp_valid; logic [31:0] exp_pc;
   } vec_t;

   tag_t        m_out[$];
   ent_t        m_fifo[$];
   logic [31:0] m_pc;
   int unsigned m_dropped, m_empty;
   bit          drv_redir, drv_ready, acc, ret, exp_ren;
   logic [31:0] drv_rpc;
   int          n_vec = 0;
   int          n_err = 0;
   vec_t        tbl[8];

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_out.delete();
      m_fifo.delete();
      m_pc      = RESET_PC;
      m_dropped = 0;
      m_empty   = 0;
   endfunction

   // Sets inputs for one cycle (called just after a rising edge) and checks the model mid-cycle.
   task automatic drive(input bit redir, input logic [31:0] rpc, input bit want_raddr,
                        input bit want_rdata, input bit ready);
      int live = 0;
      foreach (m_out[i]) if (!m_out[i].stale) live++;
      exp_ren   = !redir && (m_out.size() < MAXO) && ((m_fifo.size() + live) < DEPTH);
      drv_redir = redir;
      drv_rpc   = rpc;
      drv_ready = ready;
      acc       = want_raddr && exp_ren;
      ret       = want_rdata && (m_out.size() > 0);
      redirect_en          = redir;
      redirect_pc          = rpc;
      imem_raddr_handshake = acc;
      imem_rdata_handshake = ret;
      imem_rdata           = (m_out.size() > 0) ? mem(m_out[0].pc) : $urandom;
      inst_ready_i         = ready;
      #4;
      chk("ren", 32'(imem_ren), 32'(exp_ren));
      chk("addr", imem_addr, m_pc);
      chk("valid", 32'(inst_valid_o), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
         chk("pc", pc_o, m_fifo[0].pc);
         chk("inst", inst_o, m_fifo[0].inst);
         chk("pc_next", pc_next_o, m_fifo[0].pc + 32'd4);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_dropped", perf_dropped_o, m_dropped);
      chk("perf_empty", perf_empty_o, m_empty);
`endif
   endtask

   task automatic advance();
      tag_t t;
      @(posedge ACLK);
      #1;
      if ((m_fifo.size() == 0) && drv_ready) m_empty++;
      if ((m_fifo.size() > 0) && drv_ready && !drv_redir) void'(m_fifo.pop_front());
      if (ret) begin
         t = m_out.pop_front();
         if (drv_redir || t.stale) m_dropped++;
         else m_fifo.push_back('{inst: mem(t.pc), pc: t.pc});
      end
      if (acc) begin
         m_out.push_back('{pc: m_pc, stale: 1'b0});
         m_pc = m_pc + 32'd4;
      end
      if (drv_redir) begin
         m_fifo.delete();
         foreach (m_out[i]) m_out[i].stale = 1'b1;
         m_pc = drv_rpc;
      end
   endtask

   task automatic step(input bit redir, input logic [31:0] rpc, input bit want_raddr,
                       input bit want_rdata, input bit ready);
      drive(redir, rpc, want_raddr, want_rdata, ready);
      advance();
   endtask

   // Asynchronous assert mid-cycle: outputs must clear before any clock edge.
   task automatic do_reset(input string name);
      ARESETn = 1'b0;
      redirect_en = 1'b0;
      imem_raddr_handshake = 1'b0;
      imem_rdata_handshake = 1'b0;
      inst_ready_i = 1'b0;
      #1;
      chk({name, "_ren"}, 32'(imem_ren), 32'd0);
      chk({name, "_addr"}, imem_addr, RESET_PC);
      chk({name, "_valid"}, 32'(inst_valid_o), 32'd0);
      chk({name, "_inst"}, inst_o, 32'd0);
      chk({name, "_pc"}, pc_o, 32'd0);
      chk({name, "_pc_next"}, pc_next_o, 32'd4);
`ifdef FETCH_PERF_CNT_EN
      chk({name, "_perf_dropped"}, perf_dropped_o, 32'd0);
      chk({name, "_perf_empty"}, perf_empty_o, 32'd0);
`endif
      repeat (2) @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      model_reset();
   endtask

   task automatic expect_first_pc(input string name, input logic [31:0] target, input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
         if (inst_valid_o) begin
            chk(name, pc_o, target);
            found = 1'b1;
         end
         advance();
      end
      if (!found) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: no instruction within %0d cycles, expected pc %h", name, budget, target);
      end
   endtask

   initial begin
      // Back-to-back handshakes from reset: address k*4 issued in cycle k, delivered at k+2.
      for (int k = 0; k < 8; k++) begin
         tbl[k].raddr     = 1'b1;
         tbl[k].rdata     = (k >= 1);
         tbl[k].ready     = 1'b1;
         tbl[k].exp_ren   = 1'b1;
         tbl[k].exp_addr  = 32'(4 * k);
         tbl[k].exp_valid = (k >= 2);
         tbl[k].exp_pc    = (k >= 2) ? 32'(4 * (k - 2)) : 32'h0;
      end

      do_reset("reset");
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 32'h0, tbl[k].raddr, tbl[k].rdata, tbl[k].ready);
         chk("tbl_ren", 32'(imem_ren), 32'(tbl[k].exp_ren));
         chk("tbl_addr", imem_addr, tbl[k].exp_addr);
         chk("tbl_valid", 32'(inst_valid_o), 32'(tbl[k].exp_valid));
         chk("tbl_pc", pc_o, tbl[k].exp_pc);
         chk("tbl_pc_next", pc_next_o, tbl[k].exp_pc + 32'd4);
         if (tbl[k].exp_valid) chk("tbl_inst", inst_o, mem(tbl[k].exp_pc));
         advance();
      end

      // Stall: FIFO fills to DEPTH and issue stops, then drains in order.
      for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk("stall_ren_off", 32'(imem_ren), 32'd0);
      chk("stall_valid", 32'(inst_valid_o), 32'd1);
      advance();
      for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // Two reads in flight (0x10, 0x14) then redirect to 0x100.
      do_reset("reset2");
      step(1'b1, 32'h10, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
      expect_first_pc("redirect_first_pc", 32'h100, 20);
`ifdef FETCH_PERF_CNT_EN
      chk("redirect_dropped", perf_dropped_o, 32'd2);
`endif

      // Redirect coinciding with a response and a pop.
      do_reset("reset3");
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h400, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      chk("flush_valid", 32'(inst_valid_o), 32'd0);
      chk("flush_addr", imem_addr, 32'h400);
      advance();
      expect_first_pc("flush_first_pc", 32'h400, 20);
`ifdef FETCH_PERF_CNT_EN
      chk("flush_dropped", perf_dropped_o, 32'd2);
`endif

      // Redirect to 0x200, fetch 0x200 while draining, then redirect to 0x300.
      do_reset("reset4");
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
      expect_first_pc("b2b_first_pc", 32'h300, 20);
`ifdef FETCH_PERF_CNT_EN
      chk("b2b_dropped", perf_dropped_o, 32'd3);
`endif

      // Reset with a full FIFO, then reset in the middle of a drain.
      for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      do_reset("reset_full");
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h800, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      do_reset("reset_drain");
      expect_first_pc("resume_first_pc", RESET_PC, 20);

      // Random traffic, including redirects near the top of the address space.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? 32'hffff_fff8 : ($urandom & 32'hffff_fffc);
         step(($urandom_range(0, 15) == 0), rpc, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
